// File: rtl/led_reporter_pkg.sv
// Shared types, ASCII constants and message-geometry helpers for the LED state reporter.
package led_reporter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Prefix byte, one char per LED, then CRLF or LF.
  function automatic int unsigned msg_len(input int unsigned num_leds, input bit use_crlf);
    return 32'd1 + num_leds + (use_crlf ? 32'd2 : 32'd1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned len);
    return (len > 32'd1) ? 32'($clog2(len)) : 32'd1;
  endfunction

endpackage

// File: rtl/led_reporter_if.sv
// Byte-stream valid/ready link from the reporter to the UART transmitter.
interface led_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/led_report_fmt.sv
// Maps a message byte index and LED snapshot to the ASCII byte sent at that position.
module led_report_fmt
  import led_reporter_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 5,
  parameter logic [7:0]  PREFIX   = 8'h4C,
  parameter bit          USE_CRLF = 1'b1,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic [0:NUM_LEDS-1] snap,
  output logic [7:0]          data_c
);

  // Trailing LF is the default; earlier positions override it.
  always_comb begin
    data_c = CHAR_LF;
    if (idx == '0) data_c = PREFIX;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (32'(idx) == 32'(i) + 32'd1) data_c = snap[i] ? CHAR_1 : CHAR_0;
    end
    if (USE_CRLF && (32'(idx) == NUM_LEDS + 32'd1)) data_c = CHAR_CR;
  end

endmodule

// File: rtl/led_reporter.sv
// Reports LED state as "L<bits>\r\n" over a valid/ready byte stream on change or request.
module led_reporter
  import led_reporter_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 5,
  parameter logic [7:0]  PREFIX      = 8'h4C,
  parameter bit          AUTO_REPORT = 1'b1,
  parameter bit          USE_CRLF    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:NUM_LEDS-1] leds,
  input  logic                request,
  led_reporter_if.master      tx,
  output logic                busy
);

  localparam int unsigned    MSG_LEN  = msg_len(NUM_LEDS, USE_CRLF);
  localparam int unsigned    IDX_W    = idx_width(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 32'd1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt_c;
  logic [0:NUM_LEDS-1]   snap_q, snap_d;
  logic [0:NUM_LEDS-1]   prev_q;
  logic                  prev_ok_q;
  logic                  pending_q, pending_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            fmt_data_c;
  logic                  trigger_c;

  // prev_ok_q masks the first edge after reset so release never looks like an LED change.
  assign trigger_c = request | (AUTO_REPORT & prev_ok_q & (leds != prev_q));
  assign idx_nxt_c = idx_q + IDX_W'(1);

  led_report_fmt #(
    .NUM_LEDS (NUM_LEDS),
    .PREFIX   (PREFIX),
    .USE_CRLF (USE_CRLF),
    .IDX_W    (IDX_W)
  ) u_fmt (
    .idx    (idx_nxt_c),
    .snap   (snap_q),
    .data_c (fmt_data_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      pending_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      prev_q     <= leds;
      prev_ok_q  <= 1'b1;
      pending_q  <= pending_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state and next-output logic; the message is frozen in snap at start.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    pending_d  = pending_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c || pending_q) begin
          snap_d     = leds;
          idx_d      = '0;
          pending_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = PREFIX;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (trigger_c) pending_d = 1'b1;
        if (tx_valid_q && tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            idx_d     = idx_nxt_c;
            tx_data_d = fmt_data_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign busy        = (state_q == ST_SEND);

endmodule

// File: tb/tb_led_reporter.sv
// Directed bench for led_reporter: one auto-reporting instance and one request-only instance.
module tb_led_reporter;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:4] leds;
  logic       request;
  logic       busy_a, busy_b;

  led_reporter_if if_a ();
  led_reporter_if if_b ();

  always #5 clk = ~clk;

  led_reporter #(
    .NUM_LEDS(5), .PREFIX(8'h4C), .AUTO_REPORT(1'b1), .USE_CRLF(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .leds(leds), .request(request), .tx(if_a.master), .busy(busy_a)
  );

  led_reporter #(
    .NUM_LEDS(5), .PREFIX(8'h4C), .AUTO_REPORT(1'b0), .USE_CRLF(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .leds(leds), .request(request), .tx(if_b.master), .busy(busy_b)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] acc_a[$];
  logic [7:0] acc_b[$];
  logic       vhist[$];
  logic       rec = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference byte at position i of the report for LED vector l.
  function automatic logic [7:0] exp_byte(input logic [0:4] l, input int i);
    if (i == 0) return 8'h4C;
    if (i <= 5) return l[3'(i - 1)] ? 8'h31 : 8'h30;
    if (i == 6) return 8'h0D;
    return 8'h0A;
  endfunction

  // One cycle: drive at the falling edge, observe 1 ns later; bytes shown with ready are taken.
  task automatic tick(input logic req, input logic rdy);
    @(negedge clk);
    request       = req;
    if_a.tx_ready = rdy;
    if_b.tx_ready = rdy;
    #1;
    if (if_a.tx_valid && rdy) acc_a.push_back(if_a.tx_data);
    if (if_b.tx_valid && rdy) acc_b.push_back(if_b.tx_data);
    if (rec && (if_a.tx_valid || vhist.size() > 0)) vhist.push_back(if_a.tx_valid);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b1);
  endtask

  task automatic expect_msg(input string tag, input logic [0:4] l, input int base);
    logic [7:0] g;
    for (int i = 0; i < 8; i++) begin
      g = (base + i < acc_a.size()) ? acc_a[base + i] : 8'hEE;
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp_byte(l, i)));
    end
  endtask

  task automatic clear_logs();
    acc_a.delete();
    acc_b.delete();
    vhist.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;

    reset         = 1'b0;
    leds          = 5'b10110;
    request       = 1'b0;
    if_a.tx_ready = 1'b0;
    if_b.tx_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", 32'(if_a.tx_valid), 32'd0);
    check_eq("rst_data",  32'(if_a.tx_data),  32'h00);
    check_eq("rst_busy",  32'(busy_a),        32'd0);
    check_eq("rst_valid_b", 32'(if_b.tx_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    drain(4);
    check_eq("release_quiet", 32'(acc_a.size()), 32'd0);

    // 1: request pulse, full-rate back-to-back bytes
    tick(1'b1, 1'b1);
    check_eq("t1_latency", 32'(if_a.tx_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      check_eq($sformatf("t1_valid%0d", i), 32'(if_a.tx_valid), 32'd1);
      check_eq($sformatf("t1_busy%0d", i),  32'(busy_a),        32'd1);
      check_eq($sformatf("t1_data%0d", i),  32'(if_a.tx_data),  32'(exp_byte(5'b10110, i)));
    end
    tick(1'b0, 1'b1);
    check_eq("t1_end_valid", 32'(if_a.tx_valid), 32'd0);
    check_eq("t1_end_busy",  32'(busy_a),        32'd0);

    // 2: LED change reports only when auto-report is on
    leds = 5'b00000;
    drain(12);
    clear_logs();
    leds = 5'b00100;
    drain(12);
    check_eq("t2_len", 32'(acc_a.size()), 32'd8);
    expect_msg("t2", 5'b00100, 0);
    check_eq("t2_noauto_len", 32'(acc_b.size()), 32'd0);

    // 3: ready toggling; held data while stalled, no drops or duplicates
    clear_logs();
    leds = 5'b11001;
    pr   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      pv = if_a.tx_valid;
      pd = if_a.tx_data;
      tick(1'b0, (i % 2) == 1);
      if (pv && !pr) begin
        check_eq($sformatf("t3_hold_valid%0d", i), 32'(if_a.tx_valid), 32'd1);
        check_eq($sformatf("t3_hold_data%0d", i),  32'(if_a.tx_data),  32'(pd));
      end
      pr = (i % 2) == 1;
    end
    check_eq("t3_len", 32'(acc_a.size()), 32'd8);
    expect_msg("t3", 5'b11001, 0);
    check_eq("t3_noauto_len", 32'(acc_b.size()), 32'd0);

    // 4: changes during SEND leave message intact and coalesce into one report
    leds = 5'b00000;
    drain(12);
    clear_logs();
    rec  = 1'b1;
    leds = 5'b10000;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    leds = 5'b11000;
    tick(1'b0, 1'b1);
    leds = 5'b11100;
    tick(1'b0, 1'b1);
    leds = 5'b11110;
    drain(25);
    rec = 1'b0;
    check_eq("t4_len", 32'(acc_a.size()), 32'd16);
    expect_msg("t4_first", 5'b10000, 0);
    expect_msg("t4_second", 5'b11110, 8);
    check_eq("t4_hist_len_ok", 32'(vhist.size() >= 10), 32'd1);
    if (vhist.size() >= 10) begin
      check_eq("t4_last_byte", 32'(vhist[7]), 32'd1);
      check_eq("t4_gap",       32'(vhist[8]), 32'd0);
      check_eq("t4_restart",   32'(vhist[9]), 32'd1);
    end

    // 5: asynchronous reset mid-message aborts with no resume
    leds = 5'b01011;
    drain(12);
    clear_logs();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_valid", 32'(if_a.tx_valid), 32'd0);
    check_eq("t5_busy",  32'(busy_a),        32'd0);
    check_eq("t5_data",  32'(if_a.tx_data),  32'h00);
    #3;
    reset = 1'b1;
    drain(12);
    check_eq("t5_len", 32'(acc_a.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc_a.size())
        check_eq($sformatf("t5_byte%0d", i), 32'(acc_a[i]), 32'(exp_byte(5'b01011, i)));
    end

    // 6: request on the edge the final LF is accepted
    clear_logs();
    rec = 1'b1;
    tick(1'b1, 1'b1);
    for (int j = 0; j < 8; j++) tick(j == 7, 1'b1);
    drain(12);
    rec = 1'b0;
    check_eq("t6_len", 32'(acc_a.size()), 32'd16);
    expect_msg("t6_first", 5'b01011, 0);
    expect_msg("t6_second", 5'b01011, 8);
    check_eq("t6_hist_len_ok", 32'(vhist.size() >= 10), 32'd1);
    if (vhist.size() >= 10) begin
      check_eq("t6_gap",     32'(vhist[8]), 32'd0);
      check_eq("t6_restart", 32'(vhist[9]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
